button_event_ctrl: RTL
======================

// Module: button_event_ctrl
// PURPOSE
//  Parametrised N-channel button front end: synchroniser, debouncer, edge detector, long-press FSM, per-channel press counters.
//  Sits between raw board buttons (BUT pins) and user logic/PMOD indicators.
//  Supersedes separate debounce and edge-detect blocks with a single generalised block.
// PARAMETERS
//  N_CH        2          number of independent button channels
//  SYNC_STAGES 2          synchroniser flops per channel (>=2)
//  DEB_CYCLES  1000000    consecutive stable cycles needed to accept a change (10 ms @100 MHz, >=1)
//  LONG_CYCLES 100000000  cycles held after press before long_pulse (1 s @100 MHz, >=2)
//  ACTIVE_LOW  1          1: pin low = pressed; 0: pin high = pressed
//  CNT_W       8          press counter width per channel
// PORTS
//  clk            in   1           100 MHz system clock; all logic on rising edge
//  rst_n          in   1           synchronous active-low reset
//  btn_in         in   N_CH        raw asynchronous button pins
//  clr_count      in   N_CH        per-channel synchronous press-counter clear
//  level          out  N_CH        debounced pressed state (1 = pressed)
//  press_pulse    out  N_CH        1-cycle pulse on debounced press
//  release_pulse  out  N_CH        1-cycle pulse on debounced release
//  long_pulse     out  N_CH        1-cycle pulse when hold reaches LONG_CYCLES
//  press_count    out  N_CH*CNT_W  channel i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  Clock and reset:
//  - Single clock domain. Reset is synchronous, active-low.
//  - While rst_n=0: sync flops load the unpressed pin value (ACTIVE_LOW); all counters clear; FSMs go to IDLE.
//  - While rst_n=0: all outputs are 0.
//  - Reset asserted mid-operation aborts silently: no release_pulse is emitted.
//  Input path:
//  - btn_in passes through the synchroniser, then p = sync_out ^ ACTIVE_LOW gives the normalised pressed level.
//  Debounce:
//  - Per-channel counter. It clears whenever p == level.
//  - Otherwise it increments. On the edge where p != level and counter == DEB_CYCLES-1: level <= p and counter <= 0.
//  - Latency: level changes on the (SYNC_STAGES+DEB_CYCLES)-th rising edge, counting the first edge that samples the new pin value.
//  - A glitch shorter than DEB_CYCLES cycles resets the count and produces no change.
//  Edge pulses (registered):
//  - press_pulse is high exactly in the first cycle level reads 1.
//  - release_pulse is high exactly in the first cycle level reads 0.
//  Long-press FSM, per channel:
//  - IDLE: on debounced press -> HELD; hold_cnt <= 0.
//  - HELD: hold_cnt increments each cycle. long_pulse is high in the cycle LONG_CYCLES cycles after the press_pulse cycle; then -> LONG.
//  - HELD or LONG: on debounced release -> IDLE.
//  - Release on the same edge as the long threshold: release wins; no long_pulse.
//  - long_pulse occurs at most once per press.
//  Press counter:
//  - Increments on press_pulse, modulo 2^CNT_W (2^CNT_W-1 wraps to 0).
//  - clr_count with no press -> 0.
//  - clr_count in the same cycle as press_pulse -> 1 (no event lost).
//  Channel independence:
//  - Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
// TESTING (bench params: N_CH=2, SYNC_STAGES=2, DEB_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1, CNT_W=3)
//  1 Reset: rst_n=0 for 5 cycles, btn_in=2'b00 -> all outputs 0.
//    After release, level=2'b11 on the 6th edge; press_pulse=2'b11 for one cycle.
//  2 Bounce: ch0 toggles low for 3 cycles, high 1 cycle, repeated 5 times -> level[0], all pulses and press_count stay 0.
//  3 Clean press ch0: level[0] rises exactly 6 edges after the pin falls; press_pulse[0] for 1 cycle; press_count[0]=1.
//    Release: release_pulse[0] 6 edges after the pin rises.
//  4 Long press ch1, held 30 cycles: long_pulse[1] exactly once, 10 cycles after press_pulse[1].
//    Release 7 cycles after press: no long_pulse.
//  5 Counter: 8 clean presses on ch0 -> press_count[0] wraps to 0.
//    clr_count[0] in the press_pulse cycle -> press_count[0]=1.
//  6 Reset in HELD: rst_n=0 for 1 cycle -> outputs 0, no release_pulse.
//    Held pin re-debounces to a press 6 edges after rst_n returns to 1.

Source files
------------

// File: rtl/button_event_ctrl.sv
// N-channel button front end: synchroniser, debouncer, press/release pulses,
// long-press detection and per-channel press counters.
module button_event_ctrl #(
   parameter int unsigned N_CH        = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYCLES  = 1000000,
   parameter int unsigned LONG_CYCLES = 100000000,
   parameter int unsigned ACTIVE_LOW  = 1,
   parameter int unsigned CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH-1:0]       btn_in,
   input  logic [N_CH-1:0]       clr_count,
   output logic [N_CH-1:0]       level,
   output logic [N_CH-1:0]       press_pulse,
   output logic [N_CH-1:0]       release_pulse,
   output logic [N_CH-1:0]       long_pulse,
   output logic [N_CH*CNT_W-1:0] press_count
);

   localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int unsigned HW = $clog2(LONG_CYCLES);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
   localparam logic          IDLE_PIN  = (ACTIVE_LOW != 0);

   typedef enum logic [1:0] {StIdle, StHeld, StLong} hold_state_e;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   p;
      logic [DW-1:0]          deb_q, deb_d;
      logic                   level_q, level_d;
      logic                   press_ev, release_ev;
      logic                   press_q, release_q, long_q, long_d;
      hold_state_e            state_q, state_d;
      logic [HW-1:0]          hold_q, hold_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;

      assign p = sync_q[SYNC_STAGES-1] ^ IDLE_PIN;

      always_comb begin
         deb_d      = deb_q;
         level_d    = level_q;
         press_ev   = 1'b0;
         release_ev = 1'b0;
         if (p == level_q) begin
            deb_d = '0;
         end else if (deb_q == DEB_LAST) begin
            deb_d      = '0;
            level_d    = p;
            press_ev   = p;
            release_ev = ~p;
         end else begin
            deb_d = deb_q + 1'b1;
         end
      end

      // A release on the threshold edge takes priority, suppressing long_pulse.
      always_comb begin
         state_d = state_q;
         hold_d  = hold_q;
         long_d  = 1'b0;
         unique case (state_q)
            StIdle: begin
               if (press_ev) begin
                  state_d = StHeld;
                  hold_d  = '0;
               end
            end
            StHeld: begin
               if (release_ev) begin
                  state_d = StIdle;
               end else if (hold_q == LONG_LAST) begin
                  state_d = StLong;
                  long_d  = 1'b1;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            StLong: begin
               if (release_ev) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end

      // Clear coinciding with a press still counts that press.
      always_comb begin
         cnt_d = cnt_q;
         if (clr_count[i]) begin
            cnt_d = press_q ? CNT_W'(1) : '0;
         end else if (press_q) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            sync_q    <= {SYNC_STAGES{IDLE_PIN}};
            deb_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            state_q   <= StIdle;
            hold_q    <= '0;
            cnt_q     <= '0;
         end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
            deb_q     <= deb_d;
            level_q   <= level_d;
            press_q   <= press_ev;
            release_q <= release_ev;
            long_q    <= long_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
         end
      end

      assign level[i]                       = level_q;
      assign press_pulse[i]                 = press_q;
      assign release_pulse[i]               = release_q;
      assign long_pulse[i]                  = long_q;
      assign press_count[i*CNT_W +: CNT_W]  = cnt_q;
   end

endmodule
